// File: rtl/reg_file_rename_if.sv
// Issue/ROB/commit bundle for the rename register file.
// master drives lookups, renames, ROB forwards and commits; slave is the register file.
interface reg_file_rename_if #(
    parameter int ROB_AW = 4
);
    logic              rdy;
    logic              IS_sgn;
    logic              IS_rename;
    logic [4:0]        IS_dest;
    logic [ROB_AW-1:0] IS_ROB_name;
    logic [4:0]        IS_rs1;
    logic [4:0]        IS_rs2;
    logic              IS_rdy1;
    logic [31:0]       IS_val1;
    logic [ROB_AW-1:0] IS_tag1;
    logic              IS_rdy2;
    logic [31:0]       IS_val2;
    logic [ROB_AW-1:0] IS_tag2;
    logic [ROB_AW-1:0] ROB_ord1;
    logic [ROB_AW-1:0] ROB_ord2;
    logic              ROB_rdy1;
    logic [31:0]       ROB_val1;
    logic              ROB_rdy2;
    logic [31:0]       ROB_val2;
    logic              REG_commit_sgn;
    logic [4:0]        REG_commit_dest;
    logic [31:0]       REG_commit_value;
    logic [ROB_AW-1:0] REG_commit_ROB_name;
    logic              jp_wrong;

    modport master (
        output rdy, IS_sgn, IS_rename, IS_dest, IS_ROB_name, IS_rs1, IS_rs2,
               ROB_rdy1, ROB_val1, ROB_rdy2, ROB_val2,
               REG_commit_sgn, REG_commit_dest, REG_commit_value, REG_commit_ROB_name,
               jp_wrong,
        input  IS_rdy1, IS_val1, IS_tag1, IS_rdy2, IS_val2, IS_tag2, ROB_ord1, ROB_ord2
    );

    modport slave (
        input  rdy, IS_sgn, IS_rename, IS_dest, IS_ROB_name, IS_rs1, IS_rs2,
               ROB_rdy1, ROB_val1, ROB_rdy2, ROB_val2,
               REG_commit_sgn, REG_commit_dest, REG_commit_value, REG_commit_ROB_name,
               jp_wrong,
        output IS_rdy1, IS_val1, IS_tag1, IS_rdy2, IS_val2, IS_tag2, ROB_ord1, ROB_ord2
    );
endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with ROB-tag renaming: operand lookup with commit/ROB
// forwarding, destination rename, commit retire and mispredict flush.
module reg_file_rename #(
    parameter int ROB_AW = 4,
    parameter int REG_N  = 32
) (
    input logic               clk,
    input logic               rst,
    reg_file_rename_if.slave  bus
);
    logic [31:0]       value [REG_N];
    logic [ROB_AW-1:0] tag   [REG_N];
    logic [REG_N-1:0]  busy;

    logic [4:0]        rs      [2];
    logic              rob_rdy [2];
    logic [31:0]       rob_val [2];
    logic              lk_rdy  [2];
    logic [31:0]       lk_val  [2];
    logic [ROB_AW-1:0] lk_tag  [2];

    assign rs[0]      = bus.IS_rs1;
    assign rs[1]      = bus.IS_rs2;
    assign rob_rdy[0] = bus.ROB_rdy1;
    assign rob_rdy[1] = bus.ROB_rdy2;
    assign rob_val[0] = bus.ROB_val1;
    assign rob_val[1] = bus.ROB_val2;

    // Lookup sees the pre-rename mapping, so rs==rd reads the previous producer.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            lk_tag[k] = tag[rs[k]];
            lk_rdy[k] = 1'b0;
            lk_val[k] = '0;
            if (rs[k] == '0) begin
                lk_rdy[k] = 1'b1;
            end else if (!busy[rs[k]]) begin
                lk_rdy[k] = 1'b1;
                lk_val[k] = value[rs[k]];
            end else if (bus.REG_commit_sgn && bus.REG_commit_dest == rs[k] &&
                         bus.REG_commit_ROB_name == tag[rs[k]]) begin
                lk_rdy[k] = 1'b1;
                lk_val[k] = bus.REG_commit_value;
            end else if (rob_rdy[k]) begin
                lk_rdy[k] = 1'b1;
                lk_val[k] = rob_val[k];
            end
        end
    end

    assign bus.IS_rdy1  = lk_rdy[0];
    assign bus.IS_val1  = lk_val[0];
    assign bus.IS_tag1  = lk_tag[0];
    assign bus.ROB_ord1 = lk_tag[0];
    assign bus.IS_rdy2  = lk_rdy[1];
    assign bus.IS_val2  = lk_val[1];
    assign bus.IS_tag2  = lk_tag[1];
    assign bus.ROB_ord2 = lk_tag[1];

    logic [4:0] cd;
    assign cd = bus.REG_commit_dest;

    // Later assignments win: rename overrides the commit busy-clear, flush overrides both.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            for (int i = 0; i < REG_N; i++) begin
                value[i] <= '0;
                tag[i]   <= '0;
            end
        end else if (bus.rdy) begin
            if (bus.REG_commit_sgn && cd != '0) begin
                value[cd] <= bus.REG_commit_value;
                if (busy[cd] && tag[cd] == bus.REG_commit_ROB_name)
                    busy[cd] <= 1'b0;
            end
            if (bus.jp_wrong) begin
                busy <= '0;
            end else if (bus.IS_sgn && bus.IS_rename && bus.IS_dest != '0) begin
                busy[bus.IS_dest] <= 1'b1;
                tag[bus.IS_dest]  <= bus.IS_ROB_name;
            end
        end
    end
endmodule

// File: doc/reg_file_rename.md
Name: reg_file_rename

Overview:
- Architectural register file with ROB-tag renaming, sitting between the Issue stage and the ROB.
- Issue looks up source operands here. Lookups return a committed value, a ROB-forwarded value, or a pending ROB tag.
- Destination registers are renamed to the issuing ROB entry.
- Consumes the ROB commit stream (REG_commit_*) to retire values. Clears all renames when the ROB asserts jp_wrong.

Parameters:
- ROB_AW, 4, ROB index width (16-entry ROB).
- REG_N, 32, number of architectural registers; x0 hardwired to zero.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- rdy  input  1  global ready; when low, all state holds.
- IS_sgn  input  1  issue valid this cycle.
- IS_rename  input  1  issuing instruction writes rd (low for branch/store).
- IS_dest  input  5  rd of issuing instruction.
- IS_ROB_name  input  ROB_AW  ROB entry allocated to issuing instruction.
- IS_rs1  input  5  source register 1 index.
- IS_rs2  input  5  source register 2 index.
- IS_rdy1  output  1  operand 1 value valid.
- IS_val1  output  32  operand 1 value.
- IS_tag1  output  ROB_AW  producing ROB entry when IS_rdy1=0.
- IS_rdy2  output  1  operand 2 value valid.
- IS_val2  output  32  operand 2 value.
- IS_tag2  output  ROB_AW  producing ROB entry when IS_rdy2=0.
- ROB_ord1  output  ROB_AW  tag of rs1, sent to ROB for forwarding query.
- ROB_ord2  output  ROB_AW  tag of rs2, sent to ROB for forwarding query.
- ROB_rdy1  input  1  ROB entry ROB_ord1 has its result.
- ROB_val1  input  32  that result.
- ROB_rdy2  input  1  ROB entry ROB_ord2 has its result.
- ROB_val2  input  32  that result.
- REG_commit_sgn  input  1  commit write valid.
- REG_commit_dest  input  5  commit rd.
- REG_commit_value  input  32  commit value.
- REG_commit_ROB_name  input  ROB_AW  committing ROB entry.
- jp_wrong  input  1  mispredict flush.

Behaviour:
State per register: value[32], busy[1], tag[ROB_AW].

Reset (rst=1 at posedge):
- All value=0, busy=0, tag=0.
- Resulting outputs: IS_rdy1/2=1, IS_val1/2=0, IS_tag1/2=0, ROB_ord1/2=0.

Lookup (combinational, per source s; identical for rs2):
- ROB_ord = tag[s].
- Priority 1: s==0 -> rdy=1, val=0.
- Priority 2: !busy[s] -> rdy=1, val=value[s].
- Priority 3: busy[s] and REG_commit_sgn and REG_commit_dest==s and REG_commit_ROB_name==tag[s] -> rdy=1, val=REG_commit_value (commit bypass).
- Priority 4: busy[s] and ROB_rdy -> rdy=1, val=ROB_val.
- Otherwise: rdy=0, val=0, IS_tag=tag[s].
- The lookup uses the mapping before this cycle's rename. An instruction whose rs equals its own rd sees the previous producer.

Sequential update (posedge, rst=0, rdy=1), with d = REG_commit_dest:
- Commit: if REG_commit_sgn and d!=0, value[d] <= REG_commit_value. If additionally busy[d] and tag[d]==REG_commit_ROB_name, busy[d] <= 0.
- Rename: if IS_sgn and IS_rename and IS_dest!=0 and !jp_wrong, busy[IS_dest] <= 1 and tag[IS_dest] <= IS_ROB_name.
- Same-register conflict: rename has priority over the commit busy-clear, so busy stays 1 with the new tag. The commit value write still occurs.
- Commit whose tag does not match (stale producer): value is written, busy is unchanged.
- Flush: jp_wrong=1 -> all busy <= 0. That cycle's commit value write is still applied; any rename that cycle is dropped.
- rdy=0: no state change. Outputs remain a combinational function of held state and inputs.
- x0: value, busy and tag are never modified.

Test Plan:
- Reset then lookup rs1=5, rs2=0 -> rdy1=1, val1=0, rdy2=1, val2=0.
- Issue rd=3, ROB_name=7. Next cycle lookup rs1=3 with ROB_rdy1=0 -> ROB_ord1=7, rdy1=0, tag1=7. Then ROB_rdy1=1, ROB_val1=0x55 -> rdy1=1, val1=0x55.
- Commit rd=3, ROB=7, value 0x1234 while looking up rs1=3 in the same cycle -> bypass gives val1=0x1234. Next cycle busy[3]=0, val1=0x1234.
- Rename x4 to tag 2, then to tag 9. Commit x4, ROB=2, value 0xAA -> value[4]=0xAA, busy[4] stays 1, tag1=9 on lookup.
- Same cycle: commit x6 (tag 1) and issue rename x6 to tag 5 -> busy[6]=1, tag[6]=5, value[6]=commit value.
- Rename x1..x3, then jp_wrong=1 with a simultaneous issue rd=8 -> all lookups rdy=1 next cycle; x8 not busy.
- Issue rd=0 with IS_rename=1, and commit to x0 value 0xFF -> lookup rs1=0 gives rdy1=1, val1=0.
